muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: XLEN, default 32, operand and result width in bits; legal values 8..64, even.
REQ-002 clk  input  1  single clock; every register updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request; accepted only in IDLE.
REQ-005 op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 a, b  input  XLEN each  operands (rs1, rs2); sampled only on accept.
REQ-007 flush  input  1  abort of the in-flight operation (pipeline kill).
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  single-cycle pulse; result valid in that cycle.
REQ-010 result  output  XLEN  final value; held from done until the next accept.

Function
REQ-011 FSM states: IDLE, CALC, DONE.
- IDLE -> CALC on start=1.
- CALC -> DONE when the iteration counter reaches 0.
- DONE -> IDLE unconditionally after one cycle.
REQ-012 On accept: latch op, a and b; store operand magnitudes plus result sign; load the counter with XLEN.
REQ-013 CALC runs exactly XLEN cycles at one bit per cycle.
- Multiplies: radix-2 shift-add into a 2*XLEN accumulator.
- Divides: restoring division.
REQ-014 Latency is fixed for every op, operand value and special case.
- Accept in cycle T: done=1 in cycle T+XLEN+1.
- busy=1 in cycles T+1..T+XLEN+1.
REQ-015 MUL returns the low XLEN bits of the product. MULH, MULHSU and MULHU return the high XLEN bits, with operands treated as signed x signed, signed x unsigned and unsigned x unsigned respectively.
REQ-016 Signed ops work on magnitudes and negate the final value when required.
- Quotient sign = sign(a) XOR sign(b).
- Remainder sign = sign(a).
REQ-017 Divide by zero:
- DIV and DIVU return all ones.
- REM and REMU return a.
REQ-018 Signed overflow (a = most-negative, b = -1):
- DIV returns a.
- REM returns 0.
REQ-019 start while busy=1 is ignored; no state change and no queueing.
REQ-020 flush=1 in CALC or DONE: state becomes IDLE on the next edge, done stays 0 (a done pulse already in the current cycle stands), and result keeps its previous value.
REQ-021 flush=1 and start=1 in the same IDLE cycle: start is dropped.
REQ-022 done, busy and result are registered outputs; there is no combinational path from any input to any output.

Reset
REQ-023 rst_n=0 forces asynchronously:
- state = IDLE;
- busy = 0, done = 0;
- result = 0;
- counter = 0 and all internal datapath registers = 0.
REQ-024 Reset asserted mid-operation discards the operation and produces no done pulse. The first start after rst_n rises is accepted normally.

Configuration
REQ-025 Macro MULDIV_DIV_EN.
- Defined: all eight ops are implemented as above.
- Undefined: divider hardware is omitted. Ops 100-111 follow the same FSM and latency and return result = 0. Multiply ops are unchanged.

Verification
REQ-026 XLEN=32; start with MUL, a=7, b=-3 -> done exactly 33 cycles after accept; result=0xFFFFFFEB; busy high in cycles 1..33.
REQ-027 MULHU a=b=0xFFFFFFFF -> result=0xFFFFFFFE. MULHSU a=-1, b=0xFFFFFFFF -> result=0xFFFFFFFF. MULH a=0x80000000, b=0x80000000 -> result=0x40000000.
REQ-028 DIV a=-7, b=2 -> result=-3; REM a=-7, b=2 -> result=-1; DIVU a=7, b=0 -> result=0xFFFFFFFF; REMU a=7, b=0 -> result=7; DIV a=0x80000000, b=-1 -> result=0x80000000.
REQ-029 Assert flush 10 cycles after accept -> busy low on the next cycle, no done pulse, result unchanged. start during CALC -> ignored, and the original op completes with the correct value.
REQ-030 Drop rst_n mid-CALC -> outputs go to 0 immediately and no done pulse follows. With MULDIV_DIV_EN undefined, DIV a=9, b=3 -> done at T+33 with result=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M-style multiply/divide unit.
// One result bit per cycle; every op takes exactly XLEN+1 cycles from accept
// to the done pulse. Multiplies use radix-2 shift-add on operand magnitudes,
// divides use restoring division; signs are applied to the final value.
// Build option: define MULDIV_DIV_EN to include the divider. Without it,
// ops 100-111 run the same FSM and latency and return 0.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                sa, sb;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next, acc_next, prod_fix;
  logic [XLEN-1:0]     fin;

  // Operand sign decode and magnitudes for the op being requested
  always_comb begin
    sa    = a[XLEN-1] & ((op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110));
    sb    = b[XLEN-1] & ((op == 3'b001) | (op == 3'b100) | (op == 3'b110));
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
  end

  // Multiply step: acc = {partial product, remaining multiplier bits}, LSB first
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [XLEN:0]     div_tmp, div_diff;
  logic [2*XLEN-1:0] div_next;

  // Restoring divide step: acc = {remainder, dividend/quotient}, MSB first
  always_comb begin
    div_tmp  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_tmp - {1'b0, opnd_q};
    if (div_diff[XLEN]) begin
      div_next = {div_tmp[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

  // Select the step matching the latched op
  always_comb begin
    acc_next = op_q[2] ? div_next : mul_next;
  end
`else
  // Only the multiplier exists; divide ops still iterate for fixed latency
  always_comb begin
    acc_next = mul_next;
  end
`endif

  // Final value from the last iteration, sign applied
  always_comb begin
    prod_fix = neg_q ? -acc_next : acc_next;
    fin      = '0;
    case (op_q)
      3'b000:                 fin = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin = prod_fix[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
      3'b100, 3'b101:         fin = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
      default:                fin = neg_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
`else
      default:                fin = '0;
`endif
    endcase
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          state_d = CALC;
          cnt_d   = CW'(XLEN);
          op_d    = op;
          opnd_d  = op[2] ? mag_b : mag_a;
          acc_d   = op[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
          // Divide by zero leaves an all-ones magnitude quotient; keeping DIV
          // positive there returns all ones, and the remainder already equals a.
          case (op)
            3'b100:  neg_d = (sa ^ sb) & (b != '0);
            3'b101:  neg_d = 1'b0;
            3'b110:  neg_d = sa;
            3'b111:  neg_d = 1'b0;
            default: neg_d = sa ^ sb;
          endcase
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_next;
          cnt_d = cnt_q - CW'(1);
          if (cnt_d == '0) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = fin;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (XLEN=32).
// A behavioural model computes results with plain 64-bit arithmetic and tracks
// the expected busy/done/result timeline; one process compares every cycle.
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // model state
  bit          inflight;
  int          remaining;
  logic [31:0] m_result;
  logic [31:0] pending;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result from the arithmetic definition of each RV32M op
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, uy, p;
    longint unsigned ux_u, uy_u, pu;
    logic [63:0]     w;
    int              ix, iy;
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    uy   = longint'({32'h0, y});
    ux_u = {32'h0, x};
    uy_u = {32'h0, y};
    ix   = $signed(x);
    iy   = $signed(y);
    if (o[2] && !DIV_EN) return 32'h0;
    case (o)
      3'd0: begin p = sx * sy; w = p; return w[31:0]; end
      3'd1: begin p = sx * sy; w = p; return w[63:32]; end
      3'd2: begin p = sx * uy; w = p; return w[63:32]; end
      3'd3: begin pu = ux_u * uy_u; w = pu; return w[63:32]; end
      3'd4: begin
        if (y == 32'h0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        return ix / iy;
      end
      3'd5: begin
        if (y == 32'h0) return 32'hFFFF_FFFF;
        return x / y;
      end
      3'd6: begin
        if (y == 32'h0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        return ix % iy;
      end
      default: begin
        if (y == 32'h0) return x;
        return x % y;
      end
    endcase
  endfunction

  // Compare process: check outputs mid-cycle, then advance the model using
  // the inputs that the next rising edge will sample.
  initial begin
    inflight  = 1'b0;
    remaining = 0;
    m_result  = '0;
    pending   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        inflight  = 1'b0;
        remaining = 0;
        m_result  = '0;
      end
      check("busy", 32'(busy), 32'(inflight));
      check("done", 32'(done), 32'(inflight && remaining == 0));
      check("result", result, m_result);
      if (rst_n) begin
        if (inflight) begin
          if (flush || remaining == 0) begin
            inflight = 1'b0;
          end else begin
            remaining--;
            if (remaining == 0) m_result = pending;
          end
        end else if (start && !flush) begin
          inflight  = 1'b1;
          remaining = 32;
          pending   = model(op, a, b);
        end
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: busy still 0x%0h after %0d cycles, required 0", busy, k);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int t1);
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    t1 = cyc;
  endtask

  task automatic wait_done(input int t1, input string name, input logic [31:0] exp);
    while (done !== 1'b1 && cyc - t1 < 40) @(negedge clk);
    check({name, " latency"}, 32'(cyc - t1 + 1), 32'd33);
    check({name, " result"}, result, exp);
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] lit);
    int t1;
    check({name, " model"}, model(o, x, y), lit);
    issue(o, x, y, t1);
    wait_done(t1, name, lit);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int t1;
    int pulses;
    int kill_at;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // directed cases with hand-computed results
    run_op("MUL 7*-3",        3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("MULHU ff*ff",     3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("MULHSU -1*ff",    3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("MULH min*min",    3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
    run_op("DIV -7/2",        3'b100, 32'hFFFF_FFF9,  32'd2,         DIV_EN ? 32'hFFFF_FFFD : 32'h0);
    run_op("REM -7%2",        3'b110, 32'hFFFF_FFF9,  32'd2,         DIV_EN ? 32'hFFFF_FFFF : 32'h0);
    run_op("DIVU 7/0",        3'b101, 32'd7,          32'd0,         DIV_EN ? 32'hFFFF_FFFF : 32'h0);
    run_op("REMU 7%0",        3'b111, 32'd7,          32'd0,         DIV_EN ? 32'd7 : 32'h0);
    run_op("DIV min/-1",      3'b100, 32'h8000_0000,  32'hFFFF_FFFF, DIV_EN ? 32'h8000_0000 : 32'h0);
    run_op("REM min%-1",      3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0);
    run_op("DIV -7/0",        3'b100, 32'hFFFF_FFF9,  32'd0,         DIV_EN ? 32'hFFFF_FFFF : 32'h0);
    run_op("REM -7%0",        3'b110, 32'hFFFF_FFF9,  32'd0,         DIV_EN ? 32'hFFFF_FFF9 : 32'h0);
    run_op("DIV 9/3",         3'b100, 32'd9,          32'd3,         DIV_EN ? 32'd3 : 32'h0);
    run_op("MUL 5*6",         3'b000, 32'd5,          32'd6,         32'd30);

    // flush 10 cycles after accept: idle next cycle, no done, result held
    issue(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, t1);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    check("flush result", result, 32'd30);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("flush no done", 32'(pulses), 32'd0);

    // start during CALC is ignored
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, t1);
    repeat (5) @(posedge clk);
    #1 start = 1'b1; op = 3'b011; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(posedge clk); #1 start = 1'b0;
    wait_done(t1, "start-in-CALC", 32'hFFFF_FFEB);

    // start together with flush in IDLE is dropped
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = 3'b000; a = 32'd3; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("start+flush busy", 32'(busy), 32'd0);

    // reset in the middle of CALC
    issue(3'b000, 32'd11, 32'd13, t1);
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst result", result, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("rst no done", 32'(pulses), 32'd0);
    run_op("MUL after rst",   3'b000, 32'd11,         32'd13,        32'd143);

    // randomized traffic with stray starts and occasional flushes
    for (int i = 0; i < 120; i++) begin
      issue(3'($urandom), pick(), pick(), t1);
      kill_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 34) : 0;
      for (int c = 1; c <= 34; c++) begin
        start = ($urandom_range(0, 3) == 0);
        op    = 3'($urandom);
        a     = pick();
        b     = pick();
        flush = (c == kill_at);
        @(posedge clk); #1;
      end
      start = 1'b0;
      flush = 1'b0;
    end
    wait_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
